// File: rtl/exec_mem_ctrl.sv
// Execute/memory stage of the single-cycle RISC-V datapath: opcode classifier,
// 32-bit ALU with operand-B select, and a word-addressed data memory.
module exec_mem_ctrl #(
    parameter int DM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opCode,
    input  logic [31:0] rd1,
    input  logic [31:0] rd2,
    input  logic [31:0] imm,
    input  logic [2:0]  op,
    input  logic        ALUSrc,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] z,
    output logic        zero,
    output logic [31:0] memOut,
    output logic        isRtype,
    output logic        isItype,
    output logic        isLw,
    output logic        isStype,
    output logic        isbranch,
    output logic        isjump
);

    localparam int          AW       = (DM_WORDS > 1) ? $clog2(DM_WORDS) : 1;
    localparam logic [31:0] BYTE_LIM = 32'(4 * DM_WORDS);

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;

    logic [31:0] mem_q [DM_WORDS];
    logic [31:0] alu_b;
    logic [AW-1:0] word_idx;
    logic        in_range;

    // Opcode classifier; loads count as I-type as well as isLw.
    always_comb begin
        isRtype  = (opCode == 7'h33);
        isLw     = (opCode == 7'h03);
        isItype  = (opCode == 7'h13) || (opCode == 7'h03);
        isStype  = (opCode == 7'h23);
        isbranch = (opCode == 7'h63);
        isjump   = (opCode == 7'h6F);
    end

    assign alu_b = ALUSrc ? imm : rd2;

    always_comb begin
        z = 32'h0;
        case (op)
            ALU_AND: z = rd1 & alu_b;
            ALU_OR:  z = rd1 | alu_b;
            ALU_ADD: z = rd1 + alu_b;
            ALU_SUB: z = rd1 - alu_b;
            ALU_SLT: z = {31'h0, ($signed(rd1) < $signed(alu_b))};
            default: z = 32'h0;
        endcase
    end

    assign zero = ~|z;

    // Byte address -> word index; low two bits are ignored.
    assign word_idx = z[AW+1:2];
    assign in_range = (z < BYTE_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DM_WORDS; i++) begin
                mem_q[i] <= 32'h0;
            end
        end else if (MemWrite && in_range) begin
            mem_q[word_idx] <= rd2;
        end
    end

    assign memOut = (MemRead && rst_n && in_range) ? mem_q[word_idx] : 32'h0;

endmodule

// File: tb/tb_exec_mem_ctrl.sv
// Randomized bench for exec_mem_ctrl against a behavioural decode/ALU/memory model.
module tb_exec_mem_ctrl;

    localparam int DW  = 256;
    localparam int LIM = 4 * DW;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  opCode;
    logic [31:0] rd1, rd2, imm;
    logic [2:0]  op;
    logic        ALUSrc, MemRead, MemWrite;
    logic [31:0] z, memOut;
    logic        zero;
    logic        isRtype, isItype, isLw, isStype, isbranch, isjump;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] model_mem [DW];
    logic [31:0] exp_q [$];

    exec_mem_ctrl #(.DM_WORDS(DW)) dut (
        .clk(clk), .rst_n(rst_n), .opCode(opCode), .rd1(rd1), .rd2(rd2),
        .imm(imm), .op(op), .ALUSrc(ALUSrc), .MemRead(MemRead),
        .MemWrite(MemWrite), .z(z), .zero(zero), .memOut(memOut),
        .isRtype(isRtype), .isItype(isItype), .isLw(isLw),
        .isStype(isStype), .isbranch(isbranch), .isjump(isjump)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [5:0] ref_flags(input logic [6:0] oc);
        logic [5:0] f;
        f = 6'b0;  // {R, I, Lw, S, branch, jump}
        if (oc == 7'h33) f[5] = 1'b1;
        if (oc == 7'h13 || oc == 7'h03) f[4] = 1'b1;
        if (oc == 7'h03) f[3] = 1'b1;
        if (oc == 7'h23) f[2] = 1'b1;
        if (oc == 7'h63) f[1] = 1'b1;
        if (oc == 7'h6F) f[0] = 1'b1;
        return f;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] o);
        longint sa, sb;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        if (o == 3'd0) return a & b;
        if (o == 3'd1) return a | b;
        if (o == 3'd2) return 32'((longint'(a) + longint'(b)) % 64'h1_0000_0000);
        if (o == 3'd6) return 32'((longint'(a) - longint'(b) + 64'h1_0000_0000) % 64'h1_0000_0000);
        if (o == 3'd7) return (sa < sb) ? 32'd1 : 32'd0;
        return 32'd0;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] addr, input logic rd);
        if (!rd || addr >= LIM) return 32'h0;
        return model_mem[addr / 4];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_alu(input logic [31:0] a, input logic [31:0] b, input logic [31:0] i,
                             input logic [2:0] o, input logic src);
        rd1 = a; rd2 = b; imm = i; op = o; ALUSrc = src;
    endtask

    task automatic set_addr(input logic [31:0] addr);
        drive_alu(32'h0, rd2, addr, 3'b010, 1'b1);
    endtask

    task automatic mem_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        set_addr(addr);
        rd2 = data;
        MemWrite = 1'b1;
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
        if (rst_n && addr < LIM) model_mem[addr / 4] = data;
    endtask

    task automatic clear_model();
        for (int i = 0; i < DW; i++) model_mem[i] = 32'h0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; opCode = 7'h0; MemRead = 1'b1; MemWrite = 1'b0;
        drive_alu(32'h0, 32'h0, 32'h0, 3'b010, 1'b0);
        clear_model();
        #2;
        tests_run++;
        if (memOut !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_memout: got %h expected 00000000", memOut);
        end
        tests_run++;
        if (zero !== 1'b1 || z !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_alu: z=%h zero=%b expected z=0 zero=1", z, zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        MemRead = 1'b0;
    endtask

    task automatic test_decode();
        logic [6:0] list [7];
        logic [6:0] oc;
        logic [5:0] got, exp;
        list[0] = 7'h33; list[1] = 7'h13; list[2] = 7'h03; list[3] = 7'h23;
        list[4] = 7'h63; list[5] = 7'h6F; list[6] = 7'h00;
        for (int k = 0; k < 7 + 60; k++) begin
            oc = (k < 7) ? list[k] : ((k % 2 == 0) ? list[$urandom_range(0, 6)] : 7'($urandom));
            opCode = oc;
            #1;
            got = {isRtype, isItype, isLw, isStype, isbranch, isjump};
            exp = ref_flags(oc);
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL decode opCode=%h: got %b expected %b", oc, got, exp);
            end
        end
    endtask

    task automatic test_alu_directed();
        logic [2:0]  ops  [5];
        logic [31:0] exps [5];
        ops[0] = 3'b010; exps[0] = 32'd12;
        ops[1] = 3'b110; exps[1] = 32'hFFFF_FFFE;
        ops[2] = 3'b111; exps[2] = 32'd1;
        ops[3] = 3'b000; exps[3] = 32'd5;
        ops[4] = 3'b001; exps[4] = 32'd7;
        for (int k = 0; k < 5; k++) begin
            drive_alu(32'd5, 32'd7, 32'h0, ops[k], 1'b0);
            #1;
            tests_run++;
            if (z !== exps[k] || zero !== 1'b0) begin
                tests_failed++;
                $display("FAIL alu_dir op=%b: z=%h zero=%b expected z=%h zero=0", ops[k], z, zero, exps[k]);
            end
        end
        drive_alu(32'd9, 32'd9, 32'h0, 3'b110, 1'b0);
        #1;
        tests_run++;
        if (z !== 32'h0 || zero !== 1'b1) begin
            tests_failed++;
            $display("FAIL alu_zero: z=%h zero=%b expected z=0 zero=1", z, zero);
        end
        drive_alu(32'h28, 32'h5555, 32'hFFFF_FFFC, 3'b010, 1'b1);
        #1;
        tests_run++;
        if (z !== 32'h24) begin
            tests_failed++;
            $display("FAIL alu_imm: z=%h expected 00000024", z);
        end
    endtask

    task automatic test_alu_random();
        logic [31:0] a, b, i, e;
        logic [2:0]  o;
        logic        s;
        for (int k = 0; k < 300; k++) begin
            a = $urandom; b = $urandom; i = $urandom;
            if (k % 5 == 0) b = a;
            if (k % 7 == 0) i = a;
            o = 3'($urandom_range(0, 7));
            s = 1'($urandom_range(0, 1));
            drive_alu(a, b, i, o, s);
            #1;
            e = ref_alu(a, s ? i : b, o);
            tests_run++;
            if (z !== e || zero !== (e == 32'h0)) begin
                tests_failed++;
                $display("FAIL alu_rand a=%h b=%h imm=%h op=%b src=%b: z=%h zero=%b expected z=%h",
                         a, b, i, o, s, z, zero, e);
            end
        end
    endtask

    task automatic test_store_load();
        mem_write(32'h8, 32'hDEAD_BEEF);
        @(negedge clk);
        drive_alu(32'h0, 32'h0, 32'h8, 3'b010, 1'b1);
        MemRead = 1'b1;
        #1;
        tests_run++;
        if (memOut !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL store_load: got %h expected deadbeef", memOut);
        end
        MemRead = 1'b0;
        #1;
        tests_run++;
        if (memOut !== 32'h0) begin
            tests_failed++;
            $display("FAIL memread_off: got %h expected 00000000", memOut);
        end
        MemRead = 1'b1;
        set_addr(32'h0A);
        #1;
        tests_run++;
        if (memOut !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL unaligned_read: got %h expected deadbeef", memOut);
        end
        MemRead = 1'b0;
    endtask

    task automatic test_boundary();
        mem_write(32'(LIM), 32'h1234_5678);
        mem_write(32'(LIM - 4), 32'hCAFE_F00D);
        @(negedge clk);
        MemRead = 1'b1;
        set_addr(32'(LIM));
        #1;
        tests_run++;
        if (memOut !== 32'h0) begin
            tests_failed++;
            $display("FAIL oor_read: got %h expected 00000000", memOut);
        end
        set_addr(32'h0);
        #1;
        tests_run++;
        if (memOut !== model_mem[0]) begin
            tests_failed++;
            $display("FAIL oor_no_alias: got %h expected %h", memOut, model_mem[0]);
        end
        set_addr(32'(LIM - 4));
        #1;
        tests_run++;
        if (memOut !== 32'hCAFE_F00D) begin
            tests_failed++;
            $display("FAIL last_word: got %h expected cafef00d", memOut);
        end
        MemRead = 1'b0;
    endtask

    task automatic test_mem_random();
        logic [31:0] addr, got, exp;
        for (int k = 0; k < 200; k++) begin
            addr = (k % 6 == 0) ? 32'($urandom_range(LIM, 2 * LIM)) : 32'($urandom_range(0, LIM - 1));
            if (k % 23 == 0) addr = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                mem_write(addr, $urandom);
            end else begin
                @(negedge clk);
                MemRead = 1'($urandom_range(0, 3) != 0);
                set_addr(addr);
                exp_q.push_back(ref_read(addr, MemRead));
                #1;
                got = memOut;
                exp = exp_q.pop_front();
                tests_run++;
                if (got !== exp) begin
                    tests_failed++;
                    $display("FAIL mem_rand addr=%h rd=%b: got %h expected %h", addr, MemRead, got, exp);
                end
                MemRead = 1'b0;
            end
        end
    endtask

    task automatic test_read_during_write();
        mem_write(32'h40, 32'h1111_1111);
        @(negedge clk);
        set_addr(32'h40);
        rd2 = 32'h2222_2222;
        MemRead = 1'b1;
        MemWrite = 1'b1;
        #1;
        tests_run++;
        if (memOut !== 32'h1111_1111) begin
            tests_failed++;
            $display("FAIL rdw_old: got %h expected 11111111", memOut);
        end
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
        model_mem[32'h40 / 4] = 32'h2222_2222;
        tests_run++;
        if (memOut !== 32'h2222_2222) begin
            tests_failed++;
            $display("FAIL rdw_new: got %h expected 22222222", memOut);
        end
        MemRead = 1'b0;
    endtask

    task automatic test_reset_mid();
        int bad;
        mem_write(32'h10, 32'hA5A5_A5A5);
        @(negedge clk);
        MemRead = 1'b1;
        set_addr(32'h10);
        #1;
        rst_n = 1'b0;
        clear_model();
        #1;
        tests_run++;
        if (memOut !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_async_memout: got %h expected 00000000", memOut);
        end
        #1;
        rst_n = 1'b1;
        bad = 0;
        for (int w = 0; w < DW; w++) begin
            @(negedge clk);
            set_addr(32'(4 * w));
            #1;
            if (memOut !== 32'h0) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL reset_clear: %0d nonzero words, expected 0", bad);
        end
        @(negedge clk);
        rst_n = 1'b0;
        MemRead = 1'b0;
        mem_write(32'h20, 32'h5A5A_5A5A);
        @(negedge clk);
        rst_n = 1'b1;
        MemRead = 1'b1;
        set_addr(32'h20);
        #1;
        tests_run++;
        if (memOut !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_blocks_write: got %h expected 00000000", memOut);
        end
        mem_write(32'h20, 32'h7777_0001);
        @(negedge clk);
        set_addr(32'h20);
        #1;
        tests_run++;
        if (memOut !== 32'h7777_0001) begin
            tests_failed++;
            $display("FAIL first_write_after_reset: got %h expected 77770001", memOut);
        end
        MemRead = 1'b0;
    endtask

    initial begin
        test_reset();
        test_decode();
        test_alu_directed();
        test_alu_random();
        test_store_load();
        test_boundary();
        test_mem_random();
        test_read_during_write();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
